// File: rtl/bsg_mem_1rw_sync_mask_write_byte_req_adapter.sv
// Ready/valid front end for a 1rw sync byte-masked memory; read data is captured into a credited response FIFO.
// Optional: define BSG_MEM_REQ_ADAPTER_WRITE_ACK_EN to make writes return a zero-data acknowledge.
module bsg_mem_1rw_sync_mask_write_byte_req_adapter #(
    parameter int data_width_p    = 64,
    parameter int els_p           = 1024,
    parameter int addr_width_p    = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int mask_width_p    = data_width_p >> 3,
    parameter int resp_fifo_els_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic                    w_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic [mask_width_p-1:0] mask_i,
    output logic                    ready_and_o,
    output logic                    mem_v_o,
    output logic                    mem_w_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic [data_width_p-1:0] mem_data_o,
    output logic [mask_width_p-1:0] mem_w_mask_o,
    input  logic [data_width_p-1:0] mem_data_i,
    output logic                    v_o,
    output logic [data_width_p-1:0] data_o,
    input  logic                    yumi_i
);

    localparam int ptr_w_lp = (resp_fifo_els_p > 1) ? $clog2(resp_fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(resp_fifo_els_p + 1);

    typedef logic [ptr_w_lp-1:0] ptr_t;

    logic [cnt_w_lp-1:0]     count_q, count_d;
    logic                    pend_q, pend_d;
    logic                    pend_w_q, pend_w_d;
    logic                    live_q;
    ptr_t                    rd_ptr_q, rd_ptr_d;
    ptr_t                    wr_ptr_q, wr_ptr_d;
    logic [data_width_p-1:0] fifo_q [resp_fifo_els_p];

    logic [cnt_w_lp:0]       used;
    logic                    accept, push, pop;
    logic [data_width_p-1:0] push_data;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(resp_fifo_els_p - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

    // A slot is reserved for the in-flight read, so the FIFO can never overflow.
    assign used        = {1'b0, count_q} + (cnt_w_lp + 1)'(pend_q);
    assign ready_and_o = live_q & (used < (cnt_w_lp + 1)'(resp_fifo_els_p));
    assign accept      = v_i & ready_and_o;

    assign mem_v_o      = accept;
    assign mem_w_o      = w_i;
    assign mem_addr_o   = addr_i;
    assign mem_data_o   = data_i;
    assign mem_w_mask_o = w_i ? mask_i : '0;

`ifdef BSG_MEM_REQ_ADAPTER_WRITE_ACK_EN
    assign pend_d   = accept;
    assign pend_w_d = accept & w_i;
`else
    assign pend_d   = accept & ~w_i;
    assign pend_w_d = 1'b0;
`endif

    assign push      = pend_q;
    assign pop       = yumi_i & v_o;
    assign push_data = pend_w_q ? '0 : mem_data_i;

    assign count_d  = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    assign v_o    = (count_q != '0);
    assign data_o = fifo_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q  <= '0;
            pend_q   <= 1'b0;
            pend_w_q <= 1'b0;
            live_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            pend_q   <= pend_d;
            pend_w_q <= pend_w_d;
            live_q   <= 1'b1;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= push_data;
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_o));
            assert (!(push && !pop && (count_q == cnt_w_lp'(resp_fifo_els_p))));
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_req_adapter.sv
// Directed + random bench for the memory request adapter with a behavioural memory and response scoreboard.
module tb_bsg_mem_1rw_sync_mask_write_byte_req_adapter;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i, w_i, yumi_i;
    logic [9:0]  addr_i;
    logic [63:0] data_i;
    logic [7:0]  mask_i;
    logic        ready_and_o, mem_v_o, mem_w_o, v_o;
    logic [9:0]  mem_addr_o;
    logic [63:0] mem_data_o, mem_data_i, data_o;
    logic [7:0]  mem_w_mask_o;

    bsg_mem_1rw_sync_mask_write_byte_req_adapter #(
        .data_width_p(64), .els_p(1024), .resp_fifo_els_p(4)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
        .ready_and_o(ready_and_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous 1rw byte-masked memory: read data appears the cycle after the strobe.
    logic [63:0] mem [1024];
    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < 8; b++)
                    if (mem_w_mask_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
            end else begin
                mem_data_i <= mem[mem_addr_o];
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    logic        yumi_en = 1'b0;
    logic [63:0] sh [1024];
    logic [63:0] q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: settle, consume/produce per the reference model, advance to next falling edge.
    task automatic tick();
        logic [63:0] e;
        #1;
        yumi_i = yumi_en & v_o;
        #1;
        if (v_i && ready_and_o) begin
            acc_cnt++;
            if (w_i) begin
                for (int b = 0; b < 8; b++)
                    if (mask_i[b]) sh[addr_i][b*8 +: 8] = data_i[b*8 +: 8];
`ifdef BSG_MEM_REQ_ADAPTER_WRITE_ACK_EN
                q.push_back(64'h0);
`endif
            end else begin
                q.push_back(sh[addr_i]);
            end
        end
        if (yumi_i) begin
            rsp_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_resp observed=%h expected=none", data_o);
            end else begin
                e = q.pop_front();
                chk("resp_data", data_o, e);
            end
        end
        @(negedge clk_i);
        yumi_i = 1'b0;
    endtask

    task automatic req(input logic w, input logic [9:0] a, input logic [63:0] d, input logic [7:0] m);
        v_i = 1'b1; w_i = w; addr_i = a; data_i = d; mask_i = m;
    endtask

    task automatic drain();
        v_i = 1'b0;
        yumi_en = 1'b1;
        for (int i = 0; i < 30 && (q.size() != 0 || v_o); i++) tick();
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        chk("drain_v_o", {63'd0, v_o}, 64'd0);
    endtask

    initial begin
        int acc0;
        reset_n_i = 1'b0;
        yumi_i = 1'b0;
        req(1'b0, 10'd0, 64'd0, 8'd0);

        // 1: reset and release
        repeat (3) @(negedge clk_i);
        chk("rst_ready", {63'd0, ready_and_o}, 64'd0);
        chk("rst_mem_v", {63'd0, mem_v_o}, 64'd0);
        chk("rst_v_o", {63'd0, v_o}, 64'd0);
        v_i = 1'b0;
        reset_n_i = 1'b1;
        #1;
        chk("release_ready_same_cycle", {63'd0, ready_and_o}, 64'd0);
        @(negedge clk_i);
        chk("release_ready_next_cycle", {63'd0, ready_and_o}, 64'd1);
        chk("release_v_o", {63'd0, v_o}, 64'd0);

        // Populate a working set so the memory never returns X.
        yumi_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req(1'b1, 10'(i), {$urandom, $urandom}, 8'hFF);
            tick();
        end
        drain();

        // 2: full write then read, exact latency
        req(1'b1, 10'h10, 64'h1122334455667788, 8'hFF);
        tick();
        drain();
        yumi_en = 1'b0;
        req(1'b0, 10'h10, 64'h0, 8'hFF);
        #1;
        chk("rd_mem_v", {63'd0, mem_v_o}, 64'd1);
        chk("rd_mask_zero", {56'd0, mem_w_mask_o}, 64'd0);
        tick();
        v_i = 1'b0;
        chk("rd_lat_t1_v_o", {63'd0, v_o}, 64'd0);
        tick();
        chk("rd_lat_t2_v_o", {63'd0, v_o}, 64'd1);
        chk("rd_full_data", data_o, 64'h1122334455667788);
        drain();

        // 3: partial write merges low bytes
        req(1'b1, 10'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        tick();
        drain();
        yumi_en = 1'b0;
        req(1'b0, 10'h10, 64'h0, 8'h00);
        tick();
        v_i = 1'b0;
        tick();
        chk("merge_data", data_o, 64'h11223344AAAAAAAA);
        drain();

`ifdef BSG_MEM_REQ_ADAPTER_WRITE_ACK_EN
        yumi_en = 1'b0;
        req(1'b1, 10'h3, 64'hDEADBEEF, 8'hFF);
        tick();
        v_i = 1'b0;
        chk("ack_t1_v_o", {63'd0, v_o}, 64'd0);
        tick();
        chk("ack_t2_v_o", {63'd0, v_o}, 64'd1);
        chk("ack_data_zero", data_o, 64'd0);
        drain();
`endif

        // 4: credit back-pressure with stalled consumer
        yumi_en = 1'b0;
        acc_cnt = 0;
        rsp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            req(1'b0, 10'(i), 64'h0, 8'h0);
            tick();
        end
        chk("bp_accepted", 64'(acc_cnt), 64'd4);
        chk("bp_ready_low", {63'd0, ready_and_o}, 64'd0);
        yumi_en = 1'b1;
        for (int i = 0; i < 20 && acc_cnt < 5; i++) tick();
        chk("bp_fifth_accepted", 64'(acc_cnt), 64'd5);
        drain();
        chk("bp_all_returned", 64'(rsp_cnt), 64'd5);

        // 5: random back-to-back traffic at full rate
        acc_cnt = 0;
        yumi_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            req(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom));
            tick();
        end
        chk("rand_one_per_cycle", 64'(acc_cnt), 64'd100);
        drain();

        // 6: reset with two queued responses and one read in flight
        yumi_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req(1'b0, 10'(i), 64'h0, 8'h0);
            tick();
        end
        v_i = 1'b0;
        chk("pre_reset_v_o", {63'd0, v_o}, 64'd1);
        reset_n_i = 1'b0;
        #1;
        chk("mid_reset_v_o", {63'd0, v_o}, 64'd0);
        chk("mid_reset_ready", {63'd0, ready_and_o}, 64'd0);
        q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_no_stale", {63'd0, v_o}, 64'd0);
        end
        rsp_cnt = 0;
        yumi_en = 1'b1;
        req(1'b0, 10'h5, 64'h0, 8'h0);
        tick();
        drain();
        chk("post_reset_one_resp", 64'(rsp_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
